// File: rtl/dual_addr_scanner_pkg.sv
// dual_addr_scanner_pkg: shared state encoding and default widths
// for the dual-address scanner slice.
package dual_addr_scanner_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/dual_addr_scanner_if.sv
// dual_addr_scanner_if: control, memory and stream signals of the scanner.
// SCAN_CHECKSUM_EN adds the checksum signal.
interface dual_addr_scanner_if
  import dual_addr_scanner_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] base1;
  logic [ADDR_W-1:0] base2;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic              busy;
  logic              done;
`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport slave (
    input  start, base1, base2, count,
    input  dout1, dout2, out_ready,
    output addr1, addr2, out_valid,
    output out_data1, out_data2,
    output busy, done, checksum
  );

  modport master (
    output start, base1, base2, count,
    output dout1, dout2, out_ready,
    input  addr1, addr2, out_valid,
    input  out_data1, out_data2,
    input  busy, done, checksum
  );
`else
  modport slave (
    input  start, base1, base2, count,
    input  dout1, dout2, out_ready,
    output addr1, addr2, out_valid,
    output out_data1, out_data2,
    output busy, done
  );

  modport master (
    output start, base1, base2, count,
    output dout1, dout2, out_ready,
    input  addr1, addr2, out_valid,
    input  out_data1, out_data2,
    input  busy, done
  );
`endif

endinterface

// File: rtl/dual_addr_scanner_pair_fifo2.sv
// pair_fifo2: two-entry FIFO holding one captured word pair per entry.
// Head data is registered, so it stays stable until popped.
module pair_fifo2
  import dual_addr_scanner_pkg::*;
#(
  parameter int W = 2 * DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign w_pop = i_pop && (r_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + 2'(i_push) - 2'(w_pop);
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/dual_addr_scanner.sv
// dual_addr_scanner: walks port 1 up and port 2 down, streams word pairs.
// SCAN_CHECKSUM_EN enables an XOR checksum of all accepted beats.
module dual_addr_scanner
  import dual_addr_scanner_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  dual_addr_scanner_if.slave bus
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W-1:0]   r_base1;
  logic [ADDR_W-1:0]   r_base2;
  logic [ADDR_W-1:0]   r_addr1;
  logic [ADDR_W-1:0]   r_addr2;
  logic                r_inflight;
  logic                r_busy;
  logic                r_done;

  logic [1:0]          w_occ;
  logic                w_valid;
  logic                w_pop;
  logic                w_issue;
  logic                w_last;
  logic [2*DATA_W-1:0] w_head;

  assign w_pop  = w_valid && bus.out_ready;
  assign w_last = (r_idx == r_cnt - ONE);

  // A slot freed by this cycle's pop counts as room.
  assign w_issue = (r_state == S_ISSUE)
                && (r_idx < r_cnt)
                && ((3'(w_occ) + 3'(r_inflight))
                    < (3'd2 + 3'(w_pop)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_base1    <= '0;
      r_base2    <= '0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr1 <= r_base1 + r_idx[ADDR_W-1:0];
        r_addr2 <= r_base2 - r_idx[ADDR_W-1:0];
        r_idx   <= r_idx + ONE;
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base1 <= bus.base1;
            r_base2 <= bus.base2;
            r_cnt   <= bus.count;
            r_idx   <= '0;
            if (bus.count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue && w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((w_occ == 2'd0) && !r_inflight) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  pair_fifo2 #(
    .W (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({bus.dout1, bus.dout2}),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_data  (w_head),
    .o_count (w_occ)
  );

  assign bus.addr1     = r_addr1;
  assign bus.addr2     = r_addr2;
  assign bus.out_valid = w_valid;
  assign bus.out_data1 = w_head[2*DATA_W-1:DATA_W];
  assign bus.out_data2 = w_head[DATA_W-1:0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum
              ^ w_head[2*DATA_W-1:DATA_W]
              ^ w_head[DATA_W-1:0];
    end
  end

  assign bus.checksum = r_csum;
`endif

endmodule

// File: tb/tb_dual_addr_scanner.sv
// tb_dual_addr_scanner: random scans against an 8x64 ROM, with a
// queue scoreboard and a separate stream monitor.
module tb_dual_addr_scanner;

  localparam int AW = 3;
  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dual_addr_scanner_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dual_addr_scanner #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(int k);
    return 64'h0101010101010101 * 64'(k);
  endfunction

  assign bus.dout1 = rom(int'(bus.addr1));
  assign bus.dout2 = rom(int'(bus.addr2));

  int total = 0;
  int bad = 0;
  pair_t exp_q[$];
  int beats = 0;
  int n_done = 0;
  int cyc = 0;
  int scan_beats = 0;
  int last_cyc = 0;
  int max_gap = 0;
  int rmode = 0;
  int rph = 0;
  logic prev_done = 1'b0;
  logic stalled = 1'b0;
  logic [DW-1:0] hold1, hold2;
  logic [DW-1:0] last_csum = '0;

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rph++;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (rph % 4 == 0) || (rph % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    pair_t p;
    if (!rst_n) begin
      stalled = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_d1", bus.out_data1, hold1);
        check("stall_d2", bus.out_data2, hold2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat got=%h exp=none",
                   bus.out_data1);
        end else begin
          p = exp_q.pop_front();
          check("beat_d1", bus.out_data1, p.d1);
          check("beat_d2", bus.out_data2, p.d2);
        end
        if (scan_beats > 0 && cyc - last_cyc > max_gap)
          max_gap = cyc - last_cyc;
        last_cyc = cyc;
        scan_beats++;
        beats++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      hold1 = bus.out_data1;
      hold2 = bus.out_data2;
      if (bus.done) begin
        n_done++;
`ifdef SCAN_CHECKSUM_EN
        last_csum = bus.checksum;
`endif
        if (prev_done) begin
          total++;
          bad++;
          $display("FAIL done_width got=2 exp=1");
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic pulse_start(int b1, int b2, int cnt);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base1 = AW'(b1);
    bus.base2 = AW'(b2);
    bus.count = (AW + 1)'(cnt);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_scan(int b1, int b2, int cnt, bit extra);
    int d0;
    int b0;
    int t;
    logic [DW-1:0] cs;
    d0 = n_done;
    b0 = beats;
    cs = '0;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back('{d1: rom((b1 + i) % 8),
                        d2: rom((b2 - i + 8) % 8)});
      cs ^= rom((b1 + i) % 8) ^ rom((b2 - i + 8) % 8);
    end
    scan_beats = 0;
    max_gap = 0;
    pulse_start(b1, b2, cnt);
    if (cnt == 0) begin
      @(negedge clk);
      check("noop_done", 64'(bus.done), 64'd1);
      check("noop_busy", 64'(bus.busy), 64'd0);
    end else begin
      check("busy_on", 64'(bus.busy), 64'd1);
    end
    if (extra) begin
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.base1 = AW'(b1 + 3);
      bus.count = (AW + 1)'(8);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    t = 0;
    while (n_done == d0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", 64'(n_done - d0), 64'd1);
    check("drained", 64'(exp_q.size()), 64'd0);
    check("beat_cnt", 64'(beats - b0), 64'(cnt));
`ifdef SCAN_CHECKSUM_EN
    check("checksum", last_csum, cs);
`endif
    if (rmode == 0 && cnt > 1)
      check("thru_gap", 64'(max_gap), 64'd1);
    repeat (4) @(posedge clk);
    check("done_once", 64'(n_done - d0), 64'd1);
    exp_q.delete();
  endtask

  task automatic reset_mid();
    int b0;
    int d0;
    int t;
    b0 = beats;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{d1: rom(i), d2: rom(7 - i)});
    pulse_start(0, 7, 8);
    t = 0;
    while (beats < b0 + 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("pre_rst_beats", 64'(beats - b0 >= 3), 64'd1);
    #1;
    rst_n = 1'b0;
    d0 = n_done;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_addr1", 64'(bus.addr1), 64'd0);
    check("rst_addr2", 64'(bus.addr2), 64'd0);
    check("rst_d1", bus.out_data1, 64'd0);
    check("rst_d2", bus.out_data2, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    check("abort_no_beat", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b1, b2, c;
    bus.start = 1'b0;
    bus.base1 = '0;
    bus.base2 = '0;
    bus.count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_valid", 64'(bus.out_valid), 64'd0);
    check("init_busy", 64'(bus.busy), 64'd0);
    check("init_done", 64'(bus.done), 64'd0);
    check("init_addr1", 64'(bus.addr1), 64'd0);
    check("init_d1", bus.out_data1, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    rmode = 0;
    run_scan(0, 7, 8, 1'b0);
    run_scan(6, 1, 4, 1'b0);
    rmode = 1;
    run_scan(3, 5, 8, 1'b0);
    rmode = 0;
    run_scan(2, 2, 8, 1'b1);
    run_scan(0, 0, 0, 1'b0);
    reset_mid();
    run_scan(0, 7, 8, 1'b0);

    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      b1 = int'($urandom_range(0, 7));
      b2 = int'($urandom_range(0, 7));
      c = (n == 5) ? 0 : int'($urandom_range(1, 8));
      run_scan(b1, b2, c, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
